// File: rtl/vx_execute_lane_sequencer.sv
// ----------------------------------------------------------------------------
// vx_execute_lane_sequencer
//
// Takes one warp-wide execute request (NUM_THREADS lanes) and replays it to a
// narrow functional unit as a series of NUM_LANES-wide packets tagged with a
// packet index (pid) and start/end-of-packet flags.
//
// Optional feature (compile-time macro): EXEC_SEQ_SKIP_EMPTY_EN
//   defined   : packets whose thread-mask slice is all zero are skipped;
//               an all-zero request still emits one packet (pid 0, tmask 0).
//   undefined : every packet 0..PIDS-1 is emitted in order.
//
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   in_valid/in_ready request handshake (ready also asserted on the eop
//                     handshake so back-to-back requests have no bubble)
//   in_hdr            opaque header, replicated into every packet
//   in_tmask          warp thread mask
//   in_rs1/2/3        warp operand data, lane-major
//   out_valid/ready   packet handshake
//   out_hdr           captured header
//   out_tmask         mask slice of the current packet
//   out_tid           lowest active thread of the request (0 if none)
//   out_rs1/2/3       operand slices of the current packet
//   out_pid           packet index
//   out_sop/out_eop   first / last packet of the request
// ----------------------------------------------------------------------------
module vx_execute_lane_sequencer #(
    parameter int NUM_THREADS = 8,
    parameter int NUM_LANES   = 2,
    parameter int XLEN        = 32,
    parameter int HDR_W       = 64,
    parameter int PIDS        = NUM_THREADS / NUM_LANES,
    parameter int PID_WIDTH   = (PIDS > 1) ? $clog2(PIDS) : 1,
    parameter int NT_WIDTH    = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    input  logic [HDR_W-1:0]            in_hdr,
    input  logic [NUM_THREADS-1:0]      in_tmask,
    input  logic [NUM_THREADS*XLEN-1:0] in_rs1,
    input  logic [NUM_THREADS*XLEN-1:0] in_rs2,
    input  logic [NUM_THREADS*XLEN-1:0] in_rs3,
    output logic                        in_ready,
    output logic                        out_valid,
    output logic [HDR_W-1:0]            out_hdr,
    output logic [NUM_LANES-1:0]        out_tmask,
    output logic [NT_WIDTH-1:0]         out_tid,
    output logic [NUM_LANES*XLEN-1:0]   out_rs1,
    output logic [NUM_LANES*XLEN-1:0]   out_rs2,
    output logic [NUM_LANES*XLEN-1:0]   out_rs3,
    output logic [PID_WIDTH-1:0]        out_pid,
    output logic                        out_sop,
    output logic                        out_eop,
    input  logic                        out_ready
);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                        state_reg, state_next;
    logic [HDR_W-1:0]              hdr_reg;
    logic [NUM_THREADS-1:0]        tmask_reg;
    logic [NUM_THREADS*XLEN-1:0]   rs1_reg, rs2_reg, rs3_reg;
    logic [PID_WIDTH-1:0]          pid_reg;
    logic [NT_WIDTH-1:0]           tid_reg;
    logic                          sop_reg;

    logic [PID_WIDTH-1:0]          first_pid;
    logic [PID_WIDTH-1:0]          next_pid;
    logic [NT_WIDTH-1:0]           first_tid;
    logic                          last_pkt;
    logic                          accept;
    logic                          handshake;

`ifdef EXEC_SEQ_SKIP_EMPTY_EN
    // One "has any active thread" bit per packet, for the incoming request
    // (to pick the first packet) and the captured one (to pick the next).
    logic [PIDS-1:0] in_any;
    logic [PIDS-1:0] cur_any;

    for (genvar gi = 0; gi < PIDS; gi++) begin : g_any
        assign in_any[gi]  = |in_tmask[gi*NUM_LANES +: NUM_LANES];
        assign cur_any[gi] = |tmask_reg[gi*NUM_LANES +: NUM_LANES];
    end

    // Descending scan so the lowest qualifying index wins. The current packet
    // is last when no non-empty packet remains above it; this also makes an
    // all-zero request a single packet at pid 0.
    always_comb begin
        first_pid = '0;
        next_pid  = pid_reg;
        last_pkt  = 1'b1;
        for (int p = PIDS - 1; p >= 0; p--) begin
            if (in_any[p]) begin
                first_pid = PID_WIDTH'(p);
            end
            if (cur_any[p] && (PID_WIDTH'(p) > pid_reg)) begin
                next_pid = PID_WIDTH'(p);
                last_pkt = 1'b0;
            end
        end
    end
`else
    always_comb begin
        first_pid = '0;
        next_pid  = pid_reg + 1'b1;
        last_pkt  = (pid_reg == PID_WIDTH'(PIDS - 1));
    end
`endif

    // Lowest set bit of the incoming mask; 0 when the mask is empty.
    always_comb begin
        first_tid = '0;
        for (int t = NUM_THREADS - 1; t >= 0; t--) begin
            if (in_tmask[t]) begin
                first_tid = NT_WIDTH'(t);
            end
        end
    end

    // Next-state and handshake outputs. The request port reopens on the
    // final packet's handshake so a waiting request is taken without a gap.
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                out_valid = 1'b1;
                if (out_ready && last_pkt) begin
                    in_ready   = 1'b1;
                    state_next = in_valid ? ISSUE : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept    = in_valid && in_ready;
    assign handshake = out_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hdr_reg   <= '0;
            tmask_reg <= '0;
            rs1_reg   <= '0;
            rs2_reg   <= '0;
            rs3_reg   <= '0;
            pid_reg   <= '0;
            tid_reg   <= '0;
            sop_reg   <= 1'b0;
        end else if (accept) begin
            hdr_reg   <= in_hdr;
            tmask_reg <= in_tmask;
            rs1_reg   <= in_rs1;
            rs2_reg   <= in_rs2;
            rs3_reg   <= in_rs3;
            pid_reg   <= first_pid;
            tid_reg   <= first_tid;
            sop_reg   <= 1'b1;
        end else if (handshake && !last_pkt) begin
            pid_reg   <= next_pid;
            sop_reg   <= 1'b0;
        end
    end

    assign out_hdr   = hdr_reg;
    assign out_tid   = tid_reg;
    assign out_pid   = pid_reg;
    assign out_tmask = tmask_reg[pid_reg*NUM_LANES +: NUM_LANES];
    assign out_rs1   = rs1_reg[pid_reg*NUM_LANES*XLEN +: NUM_LANES*XLEN];
    assign out_rs2   = rs2_reg[pid_reg*NUM_LANES*XLEN +: NUM_LANES*XLEN];
    assign out_rs3   = rs3_reg[pid_reg*NUM_LANES*XLEN +: NUM_LANES*XLEN];
    // Flags are qualified by valid so they read 0 whenever nothing is offered.
    assign out_sop   = out_valid && sop_reg;
    assign out_eop   = out_valid && last_pkt;

endmodule

// File: tb/tb_vx_execute_lane_sequencer.sv
module tb_vx_execute_lane_sequencer;

    localparam int NT   = 8;
    localparam int NL   = 2;
    localparam int XLEN = 32;
    localparam int HW   = 64;
    localparam int NP   = NT / NL;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [HW-1:0]     in_hdr;
    logic [NT-1:0]     in_tmask;
    logic [NT*XLEN-1:0] in_rs1, in_rs2, in_rs3;
    logic              in_ready;
    logic              out_valid;
    logic [HW-1:0]     out_hdr;
    logic [NL-1:0]     out_tmask;
    logic [2:0]        out_tid;
    logic [NL*XLEN-1:0] out_rs1, out_rs2, out_rs3;
    logic [1:0]        out_pid;
    logic              out_sop, out_eop;
    logic              out_ready;

    always #5 clk = ~clk;

    vx_execute_lane_sequencer dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_hdr(in_hdr), .in_tmask(in_tmask),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs3(in_rs3), .in_ready(in_ready),
        .out_valid(out_valid), .out_hdr(out_hdr), .out_tmask(out_tmask),
        .out_tid(out_tid), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rs3(out_rs3),
        .out_pid(out_pid), .out_sop(out_sop), .out_eop(out_eop), .out_ready(out_ready)
    );

    typedef struct packed {
        logic [1:0]         pid;
        logic               sop;
        logic               eop;
        logic [NL-1:0]      tmask;
        logic [2:0]         tid;
        logic [NL*XLEN-1:0] rs1;
        logic [NL*XLEN-1:0] rs2;
        logic [NL*XLEN-1:0] rs3;
        logic [HW-1:0]      hdr;
    } pkt_t;

    pkt_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   pops   = 0;

    function automatic logic [31:0] opval(input int k, input int req, input int lane);
        return 32'(k << 28) | 32'(req << 8) | 32'(lane);
    endfunction

    function automatic logic [2:0] low_tid(input logic [NT-1:0] tm);
        logic [2:0] r = 3'd0;
        for (int t = NT - 1; t >= 0; t--) if (tm[t]) r = 3'(t);
        return r;
    endfunction

    // Packet indices a request produces, in emission order.
    function automatic void pid_list(input logic [NT-1:0] tm, output int lst[$]);
        lst = {};
        for (int p = 0; p < NP; p++) begin
`ifdef EXEC_SEQ_SKIP_EMPTY_EN
            if (tm[p*NL +: NL] != '0) lst.push_back(p);
`else
            lst.push_back(p);
`endif
        end
        if (lst.size() == 0) lst.push_back(0);
    endfunction

    function automatic int first_of(input logic [NT-1:0] tm);
        int lst[$];
        pid_list(tm, lst);
        return lst[0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one request, queue its expected packets, hold until accepted.
    task automatic send(input logic [NT-1:0] tm, input int req);
        int   lst[$];
        pkt_t e;
        bit   done = 0;
        pid_list(tm, lst);
        in_valid = 1'b1;
        in_tmask = tm;
        in_hdr   = 64'hDEAD_0000_0000_0000 | 64'(req);
        for (int i = 0; i < NT; i++) begin
            in_rs1[i*XLEN +: XLEN] = opval(1, req, i);
            in_rs2[i*XLEN +: XLEN] = opval(2, req, i);
            in_rs3[i*XLEN +: XLEN] = opval(3, req, i);
        end
        for (int k = 0; k < lst.size(); k++) begin
            int p = lst[k];
            e.pid   = 2'(p);
            e.sop   = (k == 0);
            e.eop   = (k == lst.size() - 1);
            e.tmask = tm[p*NL +: NL];
            e.tid   = low_tid(tm);
            e.rs1   = {opval(1, req, 2*p+1), opval(1, req, 2*p)};
            e.rs2   = {opval(2, req, 2*p+1), opval(2, req, 2*p)};
            e.rs3   = {opval(3, req, 2*p+1), opval(3, req, 2*p)};
            e.hdr   = 64'hDEAD_0000_0000_0000 | 64'(req);
            exp_q.push_back(e);
        end
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (in_ready) done = 1;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL accept_timeout req=%0d: in_ready stayed 0, expected 1", req);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_tmask = 8'h5A;   // junk while idle must not matter
        $display("request %0d tmask=%b accepted", req, tm);
    endtask

    // Monitor: every handshake pops one expected packet and compares it.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            pkt_t a, e;
            a = {out_pid, out_sop, out_eop, out_tmask, out_tid, out_rs1, out_rs2, out_rs3, out_hdr};
            checks++;
            pops++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_packet: pid=%0d sop=%0b eop=%0b, expected none", out_pid, out_sop, out_eop);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    errors++;
                    $display("FAIL packet: got pid=%0d sop=%0b eop=%0b tm=%b tid=%0d rs1=%h hdr=%h expected pid=%0d sop=%0b eop=%0b tm=%b tid=%0d rs1=%h hdr=%h",
                             a.pid, a.sop, a.eop, a.tmask, a.tid, a.rs1, a.hdr,
                             e.pid, e.sop, e.eop, e.tmask, e.tid, e.rs1, e.hdr);
                end else begin
                    $display("packet pid=%0d sop=%0b eop=%0b tm=%b tid=%0d ok", a.pid, a.sop, a.eop, a.tmask, a.tid);
                end
            end
        end
    end

    initial begin
        int n0;
        logic [NL*XLEN-1:0] held_rs1;
        reset = 1'b1; in_valid = 1'b0; in_hdr = '0; in_tmask = '0;
        in_rs1 = '0; in_rs2 = '0; in_rs3 = '0; out_ready = 1'b1;
        #12;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_in_ready",  64'(in_ready),  64'd1);
        check("reset_pid",       64'(out_pid),   64'd0);
        check("reset_hdr",       out_hdr,        64'd0);
        check("reset_rs1",       out_rs1,        64'd0);
        check("reset_sop_eop",   64'({out_sop, out_eop}), 64'd0);
        @(posedge clk); #1; reset = 1'b0;

        // T1: full mask, one packet per cycle, 1-cycle latency
        n0 = pops;
        send(8'hFF, 1);
        check("t1_latency_valid", 64'(out_valid), 64'd1);
        repeat (4) begin @(posedge clk); #1; end
        check("t1_four_consecutive", 64'(pops - n0), 64'd4);
        check("t1_idle_after", 64'(out_valid), 64'd0);

        // T2/T3 and other masks
        send(8'b0011_0000, 2);
        send(8'h00, 3);
        send(8'b1000_0001, 4);
        send(8'b0000_0100, 5);

        // T4: backpressure during pid 1
        repeat (6) @(posedge clk); #1;
        send(8'hFF, 6);
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("t4_pid1", 64'(out_pid), 64'd1);
        held_rs1 = out_rs1;
        repeat (3) begin
            @(negedge clk);
            check("t4_hold_valid", 64'(out_valid), 64'd1);
            check("t4_hold_pid",   64'(out_pid),   64'd1);
            check("t4_hold_rs1",   out_rs1,        held_rs1);
            check("t4_in_ready",   64'(in_ready),  64'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (4) @(posedge clk); #1;

        // T5: back-to-back, second request waits for the eop handshake
        send(8'hFF, 7);
        send(8'b0011_1100, 8);
        check("t5_no_bubble_valid", 64'(out_valid), 64'd1);
        check("t5_no_bubble_sop",   64'(out_sop),   64'd1);
        check("t5_first_pid",       64'(out_pid),   64'(first_of(8'b0011_1100)));
        repeat (5) @(posedge clk); #1;

        // T6: reset in the middle of a request
        send(8'hFF, 9);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("t6_pid2", 64'(out_pid), 64'd2);
        reset = 1'b1;
        #1;
        check("t6_reset_valid",    64'(out_valid), 64'd0);
        check("t6_reset_in_ready", 64'(in_ready),  64'd1);
        check("t6_reset_pid",      64'(out_pid),   64'd0);
        exp_q.delete();
        $display("reset asserted mid-request, pending packets discarded");
        @(posedge clk); #1;
        reset = 1'b0;
        send(8'hFF, 10);
        check("t6_restart_pid", 64'(out_pid), 64'd0);
        check("t6_restart_sop", 64'(out_sop), 64'd1);

        begin
            int c = 0;
            while (exp_q.size() != 0 && c < 200) begin @(posedge clk); c++; end
        end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain: %0d packets outstanding, expected 0", exp_q.size());
        end
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
